cbd_sampler_multi: RTL and testbench

- Parametrised multi-lane centered-binomial-distribution sampler for the Kyber datapath; successor to the fixed dual-lane, eta=2 `cbd`.
- Accepts one DIN_W-bit random word per lane per handshake. Buffers bits per lane and emits one signed coefficient per lane per handshake, in [-eta, +eta].
- eta is selectable at run time (2 or 3) and latched when a run starts. Bit buffering carries leftover bits across words, so eta=3 works with 32-bit input.
- Sits between the PRF/XOF output stage and NTT input buffering.

---
 rtl/cbd_sampler_multi_if.sv | 26 ++
 rtl/cbd_sampler_multi.sv | 154 +++++++++++++++
 tb/tb_cbd_sampler_multi.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cbd_sampler_multi_if.sv
// Handshake bundle between the PRF/XOF word producer, the CBD sampler and the NTT-side consumer.
interface cbd_sampler_multi_if #(
  parameter int LANES  = 2,
  parameter int DIN_W  = 32,
  parameter int DOUT_W = 16
);
  logic                    set;
  logic                    eta_sel;
  logic [LANES*DIN_W-1:0]  cbd_din;
  logic                    readin;
  logic                    ok_in;
  logic [LANES*DOUT_W-1:0] cbd_dout;
  logic                    ok_out;
  logic                    readout;
  logic                    done;

  modport master (
    output set, eta_sel, cbd_din, readin, readout,
    input  ok_in, cbd_dout, ok_out, done
  );

  modport slave (
    input  set, eta_sel, cbd_din, readin, readout,
    output ok_in, cbd_dout, ok_out, done
  );
endinterface

// File: rtl/cbd_sampler_multi.sv
// Multi-lane centered-binomial sampler: buffers random bits per lane and emits one signed
// coefficient in [-eta, +eta] per lane per output handshake, eta selectable as 2 or 3.
module cbd_sampler_multi #(
  parameter int LANES  = 2,
  parameter int DIN_W  = 32,
  parameter int NCOEF  = 256,
  parameter int DOUT_W = 16
) (
  input logic                clk,
  input logic                reset,
  cbd_sampler_multi_if.slave bus
);

  localparam int BW = 2 * DIN_W;
  localparam int FW = $clog2(BW + 1);
  localparam int CW = $clog2(NCOEF + 1);
  localparam int NW = $clog2(NCOEF * 6 + 1) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state;
  logic                    eta3;
  logic [FW-1:0]           fill;
  logic [CW-1:0]           ext_cnt;
  logic [CW-1:0]           out_cnt;
  logic [BW-1:0]           sbuf [LANES];
  logic [BW-1:0]           sbuf_nxt [LANES];
  logic [LANES*DOUT_W-1:0] dout_q;
  logic [LANES*DOUT_W-1:0] coef_nxt;
  logic                    ok_out_q;
  logic                    done_q;

  logic [FW-1:0] step;
  logic [NW-1:0] rem_coefs;
  logic [NW-1:0] rem_bits;
  logic [NW-1:0] need_bits;
  logic          ok_in_c;
  logic          accept;
  logic          extract;
  logic          consume;

  function automatic logic [DOUT_W-1:0] cbd_coef(input logic [5:0] b, input logic e3);
    logic [2:0] a;
    logic [2:0] c;
    logic [3:0] d;
    a = {2'b00, b[0]} + {2'b00, b[1]} + (e3 ? {2'b00, b[2]} : 3'd0);
    c = e3 ? ({2'b00, b[3]} + {2'b00, b[4]} + {2'b00, b[5]})
           : ({2'b00, b[2]} + {2'b00, b[3]});
    d = {1'b0, a} - {1'b0, c};
    return {{(DOUT_W-4){d[3]}}, d};
  endfunction

  // On a same-cycle extract and accept the word lands just above the post-shift fill level.
  function automatic logic [BW-1:0] buf_next(input logic [BW-1:0] cur,
                                             input logic [DIN_W-1:0] word,
                                             input logic ext, input logic acc,
                                             input logic [FW-1:0] fill_v,
                                             input logic [FW-1:0] step_v);
    logic [BW-1:0] r;
    logic [FW-1:0] pos;
    r   = ext ? (cur >> step_v) : cur;
    pos = ext ? (fill_v - step_v) : fill_v;
    if (acc) r = r | ({{(BW-DIN_W){1'b0}}, word} << pos);
    return r;
  endfunction

  assign step = eta3 ? FW'(6) : FW'(4);

  always_comb begin
    rem_coefs = NW'(NCOEF) - NW'(ext_cnt);
    rem_bits  = eta3 ? ((rem_coefs << 2) + (rem_coefs << 1)) : (rem_coefs << 2);
    need_bits = rem_bits - NW'(fill);
  end

  assign ok_in_c = (state == RUN) && (fill <= FW'(DIN_W)) && (need_bits != '0);
  assign accept  = ok_in_c && bus.readin;
  assign extract = (state == RUN) && (fill >= step) && (!ok_out_q || bus.readout);
  assign consume = ok_out_q && bus.readout;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign sbuf_nxt[k] = buf_next(sbuf[k], bus.cbd_din[k*DIN_W +: DIN_W],
                                  extract, accept, fill, step);
    assign coef_nxt[k*DOUT_W +: DOUT_W] = cbd_coef(sbuf[k][5:0], eta3);
  end

  // Abort has priority over any transfer in the same cycle and wipes all run state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      eta3     <= 1'b0;
      fill     <= '0;
      ext_cnt  <= '0;
      out_cnt  <= '0;
      dout_q   <= '0;
      ok_out_q <= 1'b0;
      done_q   <= 1'b0;
      for (int k = 0; k < LANES; k++) sbuf[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.set) begin
            state <= RUN;
            eta3  <= bus.eta_sel;
          end
        end
        RUN: begin
          if (!bus.set) begin
            state    <= IDLE;
            fill     <= '0;
            ext_cnt  <= '0;
            out_cnt  <= '0;
            dout_q   <= '0;
            ok_out_q <= 1'b0;
            for (int k = 0; k < LANES; k++) sbuf[k] <= '0;
          end else begin
            fill <= fill + (accept ? FW'(DIN_W) : FW'(0)) - (extract ? step : FW'(0));
            for (int k = 0; k < LANES; k++) sbuf[k] <= sbuf_nxt[k];
            if (extract) begin
              dout_q   <= coef_nxt;
              ok_out_q <= 1'b1;
              ext_cnt  <= ext_cnt + CW'(1);
            end else if (consume) begin
              ok_out_q <= 1'b0;
            end
            if (consume) begin
              out_cnt <= out_cnt + CW'(1);
              if (out_cnt == CW'(NCOEF - 1)) begin
                state  <= DONE;
                done_q <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          done_q   <= 1'b0;
          fill     <= '0;
          ext_cnt  <= '0;
          out_cnt  <= '0;
          ok_out_q <= 1'b0;
          for (int k = 0; k < LANES; k++) sbuf[k] <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ok_in    = ok_in_c;
  assign bus.ok_out   = ok_out_q;
  assign bus.cbd_dout = dout_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_cbd_sampler_multi.sv
// Randomised bench for cbd_sampler_multi: a bit-queue reference model predicts every coefficient.
module tb_cbd_sampler_multi;
  localparam int LANES  = 2;
  localparam int DIN_W  = 32;
  localparam int NCOEF  = 256;
  localparam int DOUT_W = 16;

  logic clk;
  logic reset;

  cbd_sampler_multi_if #(.LANES(LANES), .DIN_W(DIN_W), .DOUT_W(DOUT_W)) bus ();

  cbd_sampler_multi #(.LANES(LANES), .DIN_W(DIN_W), .NCOEF(NCOEF), .DOUT_W(DOUT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: raw bits per lane and the coefficients they must turn into.
  bit              bitq [LANES][$];
  int              expq [LANES][$];
  logic [DOUT_W-1:0] hist [LANES][$];
  int model_eta;
  int words_acc;
  int words_needed;
  int outs;
  int done_cnt;
  int cyc;
  int first_acc;
  int first_ok;
  bit late_okin;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel(input int eta);
    for (int k = 0; k < LANES; k++) begin
      bitq[k].delete();
      expq[k].delete();
      hist[k].delete();
    end
    model_eta    = eta;
    words_acc    = 0;
    words_needed = NCOEF * 2 * eta / DIN_W;
    outs         = 0;
    done_cnt     = 0;
    first_acc    = -1;
    first_ok     = -1;
    late_okin    = 1'b0;
  endtask

  task automatic pushWords();
    logic [DIN_W-1:0] w;
    int a;
    int b;
    for (int k = 0; k < LANES; k++) begin
      w = bus.cbd_din[k*DIN_W +: DIN_W];
      for (int i = 0; i < DIN_W; i++) bitq[k].push_back(w[i]);
      while (bitq[k].size() >= 2 * model_eta) begin
        a = 0;
        b = 0;
        for (int j = 0; j < model_eta; j++) a += int'(bitq[k].pop_front());
        for (int j = 0; j < model_eta; j++) b += int'(bitq[k].pop_front());
        expq[k].push_back(a - b);
      end
    end
  endtask

  // Handshakes are sampled mid-cycle, so each one seen here completes at the next rising edge.
  always @(negedge clk) begin
    logic [DOUT_W-1:0] got;
    logic [DOUT_W-1:0] want;
    cyc++;
    if (reset && bus.set) begin
      if (bus.ok_in && words_acc >= words_needed) late_okin = 1'b1;
      if (bus.readin && bus.ok_in) begin
        if (first_acc < 0) first_acc = cyc;
        pushWords();
        words_acc++;
      end
      if (bus.ok_out && first_ok < 0) first_ok = cyc;
      if (bus.ok_out && bus.readout) begin
        for (int k = 0; k < LANES; k++) begin
          got = bus.cbd_dout[k*DOUT_W +: DOUT_W];
          hist[k].push_back(got);
          if (expq[k].size() == 0) begin
            checkOutput($sformatf("coefExtra_l%0d", k), 64'(got), 64'hDEAD);
          end else begin
            want = DOUT_W'(expq[k].pop_front());
            checkOutput($sformatf("coef_l%0d_n%0d", k, outs), 64'(got), 64'(want));
          end
        end
        outs++;
      end
    end
    if (reset && bus.done) done_cnt++;
  end

  task automatic idleInputs();
    bus.set     = 1'b0;
    bus.readin  = 1'b0;
    bus.readout = 1'b0;
  endtask

  // mode 0: random words, 1: fixed 0x33../0xCC.. pattern, 2: lane0 all-ones then all-zeros.
  task automatic applyStimulus(input int eta, input int mode, input int rin_pct, input int rout_pct,
                               input int abort_at, input int reset_at, input bit stall);
    logic [DIN_W-1:0] wtab [LANES][64];
    logic [LANES*DOUT_W-1:0] held;
    int  nw;
    bit  fin;
    bit  stall_phase;
    int  stall_n;
    nw = NCOEF * 2 * eta / DIN_W;
    for (int i = 0; i < 64; i++) begin
      for (int k = 0; k < LANES; k++) begin
        wtab[k][i] = DIN_W'($urandom);
        if (mode == 1) wtab[k][i] = (k == 0) ? 32'h3333_3333 : 32'hCCCC_CCCC;
        if (mode == 2 && k == 0 && i == 0) wtab[k][i] = 32'hFFFF_FFFF;
        if (mode == 2 && k == 0 && i == 1) wtab[k][i] = 32'h0000_0000;
      end
    end
    resetModel(eta);
    fin         = 1'b0;
    stall_phase = stall;
    stall_n     = 0;
    held        = '0;
    @(posedge clk);
    #1;
    bus.set     = 1'b1;
    bus.eta_sel = (eta == 3);
    bus.readin  = 1'b0;
    bus.readout = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk);
      #1;
      if (done_cnt > 0) begin
        fin = 1'b1;
        break;
      end
      if (abort_at >= 0 && outs >= abort_at) begin
        idleInputs();
        @(posedge clk);
        #1;
        checkOutput("abortOkOut", 64'(bus.ok_out), 64'd0);
        checkOutput("abortOkIn", 64'(bus.ok_in), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("abortNoDone", 64'(done_cnt), 64'd0);
        return;
      end
      if (reset_at >= 0 && outs >= reset_at) begin
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rstOkIn", 64'(bus.ok_in), 64'd0);
        checkOutput("rstOkOut", 64'(bus.ok_out), 64'd0);
        checkOutput("rstDone", 64'(bus.done), 64'd0);
        checkOutput("rstDout", 64'(bus.cbd_dout), 64'd0);
        idleInputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstNoDone", 64'(done_cnt), 64'd0);
        return;
      end
      bus.eta_sel = 1'($urandom);
      for (int k = 0; k < LANES; k++)
        bus.cbd_din[k*DIN_W +: DIN_W] = (words_acc < nw) ? wtab[k][words_acc] : DIN_W'($urandom);
      bus.readin = ($urandom_range(99) < rin_pct);
      if (stall_phase) begin
        bus.readout = 1'b0;
        if (bus.ok_out) begin
          if (stall_n == 0) begin
            held = bus.cbd_dout;
          end else begin
            checkOutput("stallOkOut", 64'(bus.ok_out), 64'd1);
            checkOutput("stallDout", 64'(bus.cbd_dout), 64'(held));
          end
          stall_n++;
          if (stall_n == 7) begin
            checkOutput("stallOkInLow", 64'(bus.ok_in), 64'd0);
            stall_phase = 1'b0;
          end
        end
      end else begin
        bus.readout = ($urandom_range(99) < rout_pct);
      end
    end
    idleInputs();
    checkOutput("runFinished", 64'(fin), 64'd1);
    checkOutput("wordsAccepted", 64'(words_acc), 64'(nw));
    checkOutput("coefsConsumed", 64'(outs), 64'(NCOEF));
    checkOutput("modelDrained", 64'(expq[0].size() + expq[1].size()), 64'd0);
    checkOutput("okInAfterLast", 64'(late_okin), 64'd0);
    if (mode == 1) begin
      checkOutput("firstOkLatency", 64'(first_ok - first_acc), 64'd2);
      checkOutput("basicLane0", 64'(hist[0][0]), 64'h0002);
      checkOutput("basicLane1", 64'(hist[1][0]), 64'hFFFE);
    end
    if (mode == 2) begin
      checkOutput("straddleCoef0", 64'(hist[0][0]), 64'h0000);
      checkOutput("straddleCoef4", 64'(hist[0][4]), 64'h0000);
      checkOutput("straddleCoef5", 64'(hist[0][5]), 64'h0002);
      checkOutput("straddleCoef6", 64'(hist[0][6]), 64'h0000);
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("donePulseOnce", 64'(done_cnt), 64'd1);
    checkOutput("idleOkOut", 64'(bus.ok_out), 64'd0);
    checkOutput("idleOkIn", 64'(bus.ok_in), 64'd0);
  endtask

  initial begin
    cyc         = 0;
    reset       = 1'b0;
    bus.set     = 1'b0;
    bus.eta_sel = 1'b0;
    bus.cbd_din = '0;
    bus.readin  = 1'b0;
    bus.readout = 1'b0;
    resetModel(2);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetOkIn", 64'(bus.ok_in), 64'd0);
    checkOutput("resetOkOut", 64'(bus.ok_out), 64'd0);
    checkOutput("resetDone", 64'(bus.done), 64'd0);
    checkOutput("resetDout", 64'(bus.cbd_dout), 64'd0);
    reset = 1'b1;

    applyStimulus(2, 1, 100, 100, -1, -1, 1'b0);
    applyStimulus(3, 2, 100, 100, -1, -1, 1'b0);
    applyStimulus(2, 0, 100, 70, -1, -1, 1'b1);
    applyStimulus(3, 0, 80, 60, -1, -1, 1'b0);
    applyStimulus(2, 0, 90, 90, 100, -1, 1'b0);
    applyStimulus(3, 0, 70, 80, -1, -1, 1'b0);
    applyStimulus(3, 0, 90, 90, -1, 60, 1'b0);
    applyStimulus(2, 0, 60, 50, -1, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
